// File: rtl/pwm_gen_if.sv
// rtl/pwm_gen_if.sv - register-side and output bundle of the PWM generator
//
// Purpose: groups the programmed period/duty values and the PWM outputs.
// Signals:
//   period_ticks      WIDTH  requested period in clk cycles (0 = disabled)
//   duty_cycle_ticks  WIDTH  requested high time in clk cycles
//   pulse             1      PWM output
//   period_start      1      strobe on the first cycle of every active period
// Modports:
//   master  programming side (drives period/duty, observes outputs)
//   slave   generator side (pwm_gen)
interface pwm_gen_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] period_ticks;
  logic [WIDTH-1:0] duty_cycle_ticks;
  logic             pulse;
  logic             period_start;

  modport master (
    output period_ticks,
    output duty_cycle_ticks,
    input  pulse,
    input  period_start
  );

  modport slave (
    input  period_ticks,
    input  duty_cycle_ticks,
    output pulse,
    output period_start
  );
endinterface

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running glitch-free PWM generator
//
// Purpose: one pulse per period of period_ticks cycles, high for the first
// duty_cycle_ticks cycles. Period/duty are captured into shadow registers
// only at period boundaries, so a running period always completes with the
// values it started with.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous active-low reset
//   bus   pwm_gen_if.slave: period_ticks/duty_cycle_ticks in,
//         pulse/period_start out
module pwm_gen #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  pwm_gen_if.slave bus
);

  logic [WIDTH-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] p_act_q, p_act_d;
  logic [WIDTH-1:0] d_act_q, d_act_d;
  logic             active;
  logic             reload;

  // A zero period means idle; the shadows keep reloading every cycle so a
  // newly programmed period is picked up on the very next edge.
  assign active = (p_act_q != '0);
  assign reload = !active || (cnt_q == p_act_q - WIDTH'(1));

  always_comb begin
    cnt_d   = cnt_q + WIDTH'(1);
    p_act_d = p_act_q;
    d_act_d = d_act_q;
    if (reload) begin
      cnt_d   = '0;
      p_act_d = bus.period_ticks;
      d_act_d = bus.duty_cycle_ticks;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      p_act_q <= '0;
      d_act_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      p_act_q <= p_act_d;
      d_act_q <= d_act_d;
    end
  end

  // Outputs decode state only; a duty at or above the period simply keeps
  // the compare true for the whole period.
  assign bus.pulse        = active && (cnt_q < d_act_q);
  assign bus.period_start = active && (cnt_q == '0);

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - directed scoreboard bench for pwm_gen
module tb_pwm_gen;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;

  pwm_gen_if #(.WIDTH(WIDTH)) bus ();

  pwm_gen #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each entry: {pulse, period_start} expected for one sampled cycle.
  logic [1:0] exp_q[$];
  int         n_assert;
  int         n_fail;
  string      phase;

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(2'b00);
  endtask

  task automatic push_period(input int p, input int d);
    for (int k = 0; k < p; k++) begin
      exp_q.push_back({(k < d) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0});
    end
  endtask

  task automatic tick(input int n);
    logic [1:0] e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      n_assert++;
      assert (exp_q.size() != 0)
      else begin
        n_fail++;
        $error("FAIL %s scoreboard_empty: observed 0 entries expected >0", phase);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_assert++;
        assert (bus.pulse === e[1])
        else begin
          n_fail++;
          $error("FAIL %s pulse step %0d: observed %b expected %b", phase, i, bus.pulse, e[1]);
        end
        n_assert++;
        assert (bus.period_start === e[0])
        else begin
          n_fail++;
          $error("FAIL %s period_start step %0d: observed %b expected %b", phase, i, bus.period_start, e[0]);
        end
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;

    // Reset held with P=100/D=50 programmed: outputs stay low.
    phase = "reset_hold";
    rst = 1'b0;
    bus.period_ticks     = 100;
    bus.duty_cycle_ticks = 50;
    push_idle(10);
    tick(10);

    // Release: idle shadows reload on the first edge, period starts at once.
    phase = "run_100_50";
    rst = 1'b1;
    push_period(100, 50);
    push_period(100, 50);
    tick(200);

    // Duty change mid-period only takes effect at the next boundary.
    phase = "duty_to_25";
    push_period(100, 50);
    tick(30);
    bus.duty_cycle_ticks = 25;
    tick(70);
    push_period(100, 25);
    push_period(100, 25);
    tick(200);

    phase = "duty_to_75";
    push_period(100, 25);
    tick(10);
    bus.duty_cycle_ticks = 75;
    tick(90);
    push_period(100, 75);
    tick(100);

    // Duty 0: never high, strobe continues.
    phase = "duty_0";
    push_period(100, 75);
    tick(5);
    bus.duty_cycle_ticks = 0;
    tick(95);
    push_period(100, 0);
    tick(50);
    bus.duty_cycle_ticks = 100;
    tick(50);

    // Duty equal to and above the period: constantly high.
    phase = "duty_ge_period";
    push_period(100, 100);
    tick(50);
    bus.duty_cycle_ticks = 150;
    tick(50);
    push_period(100, 150);
    tick(50);
    bus.period_ticks     = 1;
    bus.duty_cycle_ticks = 1;
    tick(50);

    // Period 1: reload every cycle, pulse and strobe constantly high.
    phase = "period_1";
    for (int i = 0; i < 5; i++) push_period(1, 1);
    tick(5);

    // Period 0 disables after the current one-cycle period.
    phase = "period_0";
    bus.period_ticks = 0;
    push_idle(5);
    tick(5);

    // From idle, P=10/D=3 starts on the next edge.
    phase = "run_10_3";
    bus.period_ticks     = 10;
    bus.duty_cycle_ticks = 3;
    push_period(10, 3);
    push_period(10, 3);
    push_period(10, 3);
    tick(30);

    // Reset during the high phase aborts the period; restart is a fresh one.
    phase = "mid_reset";
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
    tick(2);
    rst = 1'b0;
    push_idle(1);
    tick(1);
    rst = 1'b1;
    push_period(10, 3);
    push_period(10, 3);
    tick(20);

    phase = "drain";
    n_assert++;
    assert (exp_q.size() == 0)
    else begin
      n_fail++;
      $error("FAIL %s leftover_entries: observed %0d expected 0", phase, exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
